calc_accum: RTL

CALC_ACCUM -- requirements
Module: calc_accum

---
 rtl/calc_pkg.sv | 25 ++
 rtl/button.sv | 44 ++++
 rtl/calc_alu.sv | 57 +++++
 rtl/hex2seven_seg.sv | 32 +++
 rtl/calc_accum.sv | 136 +++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calc_accum calculator.
//   mode_e      - operation select encoding (ADD/SUB/ACC/CLR)
//   state_e     - control FSM state encoding (IDLE/EXEC)
//   OPCOUNT_MAX - saturation value of the operation counter
//   DEB_CNT_MAX - cycles the synchronised button must stay changed before it is accepted
package calc_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  localparam logic [7:0] OPCOUNT_MAX = 8'd255;

  localparam int DEB_CNT_MAX = 8;
  localparam int DEB_CNT_W   = 4;

endpackage

// File: rtl/button.sv
// button: debounce and rising-edge detect for a raw push-button.
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset (clears all debounce state)
//   i_btn   - raw, possibly bouncing, button level
//   o_push  - single-cycle pulse on each accepted press
module button
  import calc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_push
);

  logic [1:0]           r_sync;
  logic                 r_stable;
  logic                 r_stable_d;
  logic [DEB_CNT_W-1:0] r_cnt;

  // The counter restarts whenever the synchronised level agrees with the
  // accepted level, so any bounce shorter than the window is discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync     <= {r_sync[0], i_btn};
      r_stable_d <= r_stable;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_CNT_W'(DEB_CNT_MAX)) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_push = r_stable & ~r_stable_d;

endmodule

// File: rtl/calc_alu.sv
// calc_alu: combinational arithmetic for calc_accum.
//   i_mode  - operation select
//   i_a     - operand A
//   i_b     - operand B (used by ADD and SUB)
//   i_acc   - previous result (used by ACC in place of B)
//   o_res   - result, modulo 2^WIDTH
//   o_carry - unsigned carry (ADD/ACC) or borrow (SUB)
//   o_ovf   - signed two's-complement overflow
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_rhs;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

  assign w_rhs  = (i_mode == MODE_ACC) ? i_acc : i_b;
  assign w_sum  = {1'b0, i_a} + {1'b0, w_rhs};
  // The extra top bit of the widened difference is set exactly when A < B.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_res   = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    case (i_mode)
      MODE_ADD, MODE_ACC: begin
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_a[WIDTH-1] == w_rhs[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      MODE_SUB: begin
        o_res   = w_diff[WIDTH-1:0];
        o_carry = w_diff[WIDTH];
        o_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      default: begin
        o_res   = '0;
        o_carry = 1'b0;
        o_ovf   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hex2seven_seg.sv
// hex2seven_seg: one hex nibble to an active-high seven-segment pattern.
//   i_hex - nibble to display
//   o_seg - segments {g,f,e,d,c,b,a}, segment a in bit 0
module hex2seven_seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_hex)
      4'h0: o_seg = 7'h3F;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5B;
      4'h3: o_seg = 7'h4F;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6D;
      4'h6: o_seg = 7'h7D;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7F;
      4'h9: o_seg = 7'h6F;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7C;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5E;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/calc_accum.sv
// calc_accum: push-button calculator with accumulator and hex displays.
//   clk          - system clock
//   reset        - asynchronous active-low reset (release synchronised to clk)
//   gobutt       - raw button, one operation per press
//   mode         - 00 ADD, 01 SUB, 10 ACC, 11 CLR
//   switches1/2  - operands A and B
//   carryled     - carry/borrow of the last operation
//   overloadled  - signed overflow of the last operation
//   done         - one-cycle pulse when the result register updates
//   opcount      - completed non-CLR operations, saturating at 255
//   seg_a/b/res  - seven-segment images, least-significant digit in [6:0]
module calc_accum
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gobutt,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      switches1,
  input  logic [WIDTH-1:0]      switches2,
  output logic                  carryled,
  output logic                  overloadled,
  output logic                  done,
  output logic [7:0]            opcount,
  output logic [7*DIGITS-1:0]   seg_a,
  output logic [7*DIGITS-1:0]   seg_b,
  output logic [7*DIGITS-1:0]   seg_res
);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic             w_push;
  state_e           r_state;
  state_e           w_next;
  logic             w_capture;
  logic             w_exec;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_ovf;
  logic             r_done;
  logic [7:0]       r_opcount;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;

  // Assert immediately, release two clocks after reset goes high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  button u_button (
    .i_clk   (clk),
    .i_rst_n (w_rst_n),
    .i_btn   (gobutt),
    .o_push  (w_push)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // EXEC always lasts one cycle, so a push seen there is simply dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_push) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == ST_IDLE) && w_push;
    w_exec    = (r_state == ST_EXEC);
  end

  // Operands are frozen at the press so later switch/mode changes cannot
  // disturb the operation in flight; these are never read before loading.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mode <= mode_e'(mode);
      r_a    <= switches1;
      r_b    <= switches2;
    end
  end

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .i_mode  (r_mode),
    .i_a     (r_a),
    .i_b     (r_b),
    .i_acc   (r_res),
    .o_res   (w_alu_res),
    .o_carry (w_alu_carry),
    .o_ovf   (w_alu_ovf)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_opcount <= '0;
    end else begin
      r_done <= w_exec;
      if (w_exec) begin
        r_res   <= w_alu_res;
        r_carry <= w_alu_carry;
        r_ovf   <= w_alu_ovf;
        if (r_mode == MODE_CLR)             r_opcount <= '0;
        else if (r_opcount != OPCOUNT_MAX)  r_opcount <= r_opcount + 8'd1;
      end
    end
  end

  assign carryled    = r_carry;
  assign overloadled = r_ovf;
  assign done        = r_done;
  assign opcount     = r_opcount;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    hex2seven_seg u_seg_a   (.i_hex(switches1[4*g +: 4]), .o_seg(seg_a[7*g +: 7]));
    hex2seven_seg u_seg_b   (.i_hex(switches2[4*g +: 4]), .o_seg(seg_b[7*g +: 7]));
    hex2seven_seg u_seg_res (.i_hex(r_res[4*g +: 4]),     .o_seg(seg_res[7*g +: 7]));
  end

endmodule
